down_timer: RTL

//   Loadable down-counting timer, the counterpart of the free-running 4-bit up-counter.

---
 rtl/down_timer.sv | 84 ++++++++
 1 files changed

// File: rtl/down_timer.sv
// Loadable down-counting interval timer with one-cycle terminal-count pulse
// and optional auto-reload. Every output is a register; nothing is combinational from the inputs.
//
//   state  | meaning
//   -------+---------------------------------------------------
//   S_IDLE | not counting; count holds its last value, busy=0
//   S_RUN  | decrementing on enabled cycles, busy=1
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    input  logic             i_stop,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_reload <= i_load_value;
                r_count  <= i_load_value;
                if (i_load_value == '0) begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b1;
                end
            end else if (r_state == S_RUN) begin
                if (i_stop) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end else if (i_enable) begin
                    if (r_count > WIDTH'(1)) begin
                        r_count <= r_count - WIDTH'(1);
                    end else if (r_count == WIDTH'(1)) begin
                        r_done <= 1'b1;
                        if (i_auto_reload) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        // Zero in RUN is unreachable; fall back to idle instead of wrapping.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
